// File: rtl/rom_arbiter.sv
// Two-port arbiter (IFU / LSU) sharing one combinational ROM, one transaction in flight.
// Round-robin grant on contention; misaligned or out-of-range reads return an access fault.
module rom_arbiter #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_rsp_valid,
    input  logic          ifu_rsp_ready,
    output logic [31:0]   ifu_rdata,
    output logic          ifu_rsp_err,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    output logic          lsu_rsp_valid,
    input  logic          lsu_rsp_ready,
    output logic [31:0]   lsu_rdata,
    output logic          lsu_rsp_err,

    output logic [AW-1:0] rom_addr,
    input  logic [31:0]   rom_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;

    logic          grant_lsu, grant_ifu;
    logic          idle_ok;
    logic          ifu_accept, lsu_accept;
    logic          rsp_active, owner_rsp_ready;
    logic          addr_ok;
    logic [AW:0]   word_idx;
    logic [31:0]   rsp_data;

    // prio_q=0 favours the LSU, prio_q=1 favours the IFU
    always_comb begin
        grant_lsu     = lsu_req_valid & (~ifu_req_valid | ~prio_q);
        grant_ifu     = ifu_req_valid & ~grant_lsu;
        idle_ok       = (state_q == IDLE) & rst_n;
        ifu_req_ready = idle_ok & grant_ifu;
        lsu_req_ready = idle_ok & grant_lsu;
        ifu_accept    = ifu_req_valid & ifu_req_ready;
        lsu_accept    = lsu_req_valid & lsu_req_ready;
    end

    always_comb begin
        rsp_active      = (state_q == RESP);
        owner_rsp_ready = (owner_q == OWNER_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        word_idx        = {3'b000, addr_q[AW-1:2]};
        addr_ok         = (addr_q[1:0] == 2'b00) && (word_idx < DEPTH_W);
        rsp_data        = addr_ok ? rom_data : 32'h0;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (ifu_accept || lsu_accept) begin
                    state_d = RESP;
                    owner_d = lsu_accept ? OWNER_LSU : OWNER_IFU;
                    addr_d  = lsu_accept ? lsu_addr : ifu_addr;
                    // hand priority to whoever was not just served
                    prio_d  = lsu_accept;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= OWNER_IFU;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        rom_addr      = addr_q;
        ifu_rsp_valid = rsp_active & (owner_q == OWNER_IFU);
        lsu_rsp_valid = rsp_active & (owner_q == OWNER_LSU);
        ifu_rdata     = ifu_rsp_valid ? rsp_data : 32'h0;
        lsu_rdata     = lsu_rsp_valid ? rsp_data : 32'h0;
        ifu_rsp_err   = ifu_rsp_valid & ~addr_ok;
        lsu_rsp_err   = lsu_rsp_valid & ~addr_ok;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: per-requester expected-response queues filled by the
// drivers, a negedge monitor that checks responses, grant rules and latency.
module tb_rom_arbiter;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
    logic          lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
    logic [AW-1:0] ifu_addr, lsu_addr, rom_addr;
    logic [31:0]   ifu_rdata, lsu_rdata, rom_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rdy_mode;
    bit   fav_ifu;
    bit   pend_valid;
    bit   pend_who;
    int   last_ifu_hs;
    rsp_t ifu_q[$];
    rsp_t lsu_q[$];
    bit   served_who[$];
    int   served_cyc[$];

    always #5 clk = ~clk;

    rom_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rdata     (ifu_rdata),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rdata     (lsu_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data)
    );

    // ROM contents: a scrambled function of the word index, defined beyond DEPTH too
    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        return ({2'b00, idx} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign rom_data = rom_word(rom_addr[31:2]);

    function automatic rsp_t model(input logic [31:0] a);
        rsp_t r;
        if (a[1:0] == 2'b00 && a[31:2] < 30'(DEPTH)) begin
            r.data = rom_word(a[31:2]);
            r.err  = 1'b0;
        end else begin
            r.data = 32'h0;
            r.err  = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0:       a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            1:       a = {20'h0, 10'($urandom_range(256, 1023)), 2'b00};
            default: a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
        return a;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_req(input bit who, input logic [31:0] a, output int waited);
        bit got;
        got    = 1'b0;
        waited = 0;
        if (who) begin
            lsu_req_valid = 1'b1;
            lsu_addr      = a;
            lsu_q.push_back(model(a));
        end else begin
            ifu_req_valid = 1'b1;
            ifu_addr      = a;
            ifu_q.push_back(model(a));
        end
        while (!got && waited < 200) begin
            @(negedge clk);
            got = who ? lsu_req_ready : ifu_req_ready;
            @(posedge clk);
            #1;
            if (!got) waited++;
        end
        if (who) lsu_req_valid = 1'b0;
        else     ifu_req_valid = 1'b0;
        if (!got) begin
            chk(1'b0, who ? "lsu_accept_timeout" : "ifu_accept_timeout", 64'(waited), 64'd200);
            if (who) void'(lsu_q.pop_back());
            else     void'(ifu_q.pop_back());
        end
    endtask

    task automatic check_side(input bit who, input logic v, input logic rdy,
                              input logic [31:0] d, input logic e);
        rsp_t exp;
        if (v) begin
            if ((who ? lsu_q.size() : ifu_q.size()) == 0) begin
                chk(1'b0, who ? "lsu_unexpected_rsp" : "ifu_unexpected_rsp", {d, 31'h0, e}, 0);
            end else begin
                exp = who ? lsu_q[0] : ifu_q[0];
                chk(d == exp.data && e == exp.err, who ? "lsu_rsp" : "ifu_rsp",
                    {d, 31'h0, e}, {exp.data, 31'h0, exp.err});
                if (rdy) begin
                    if (who) void'(lsu_q.pop_front());
                    else     void'(ifu_q.pop_front());
                end
            end
        end else begin
            chk(d == 32'h0 && !e, who ? "lsu_idle_zero" : "ifu_idle_zero", {d, 31'h0, e}, 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_q.delete();
        lsu_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        bit busy, e_i, e_l;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                fav_ifu    = 1'b0;
                pend_valid = 1'b0;
                chk({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err,
                     ifu_req_ready, lsu_req_ready} == 6'b0 && ifu_rdata == 0 && lsu_rdata == 0
                    && rom_addr == 0, "reset_outputs",
                    {ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready, rom_addr}, 0);
            end else begin
                busy = ifu_rsp_valid | lsu_rsp_valid;
                chk(!(ifu_rsp_valid && lsu_rsp_valid), "single_owner",
                    {ifu_rsp_valid, lsu_rsp_valid}, 0);
                if (busy) begin
                    e_i = 1'b0;
                    e_l = 1'b0;
                end else if (ifu_req_valid && lsu_req_valid) begin
                    e_i = fav_ifu;
                    e_l = !fav_ifu;
                end else begin
                    e_i = ifu_req_valid;
                    e_l = lsu_req_valid;
                end
                chk({ifu_req_ready, lsu_req_ready} == {e_i, e_l}, "req_ready",
                    {ifu_req_ready, lsu_req_ready}, {e_i, e_l});
                if (pend_valid) begin
                    chk((pend_who ? lsu_rsp_valid : ifu_rsp_valid) == 1'b1, "rsp_latency",
                        {ifu_rsp_valid, lsu_rsp_valid}, pend_who ? 2'b01 : 2'b10);
                    pend_valid = 1'b0;
                end
                check_side(1'b0, ifu_rsp_valid, ifu_rsp_ready, ifu_rdata, ifu_rsp_err);
                check_side(1'b1, lsu_rsp_valid, lsu_rsp_ready, lsu_rdata, lsu_rsp_err);
                if (ifu_rsp_valid && ifu_rsp_ready) last_ifu_hs = cyc;
                if (ifu_req_valid && ifu_req_ready) begin
                    fav_ifu = 1'b0;
                    served_who.push_back(1'b0);
                    served_cyc.push_back(cyc);
                    pend_valid = 1'b1;
                    pend_who   = 1'b0;
                end
                if (lsu_req_valid && lsu_req_ready) begin
                    fav_ifu = 1'b1;
                    served_who.push_back(1'b1);
                    served_cyc.push_back(cyc);
                    pend_valid = 1'b1;
                    pend_who   = 1'b1;
                end
            end
        end
    end

    initial begin : rsp_ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                ifu_rsp_ready = 1'($urandom_range(0, 1));
                lsu_rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  w0, w1;
        bit  alt_ok;
        rsp_t e;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_addr      = '0;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        rdy_mode      = 1;
        last_ifu_hs   = 0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // IFU-only fetch of word 2
        drive_req(1'b0, 32'h8, w0);
        chk(w0 == 0, "ifu_ready_same_cycle", 64'(w0), 0);
        @(negedge clk);
        chk(ifu_rsp_valid && ifu_rdata == rom_word(30'd2) && !ifu_rsp_err, "ifu_word2",
            {ifu_rsp_valid, ifu_rdata}, {1'b1, rom_word(30'd2)});
        repeat (2) @(posedge clk);
        #1 do_reset();

        // Contention from reset: LSU first, IFU two cycles later
        served_who.delete();
        served_cyc.delete();
        fork
            drive_req(1'b0, 32'h0, w0);
            drive_req(1'b1, 32'h4, w1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk(served_who.size() == 2 && served_who[0] == 1'b1 && served_who[1] == 1'b0,
            "contention_order", 64'(served_who.size()), 2);
        chk(served_cyc.size() == 2 && served_cyc[1] - served_cyc[0] == 2, "accept_spacing",
            64'(served_cyc.size() == 2 ? served_cyc[1] - served_cyc[0] : -1), 2);
        do_reset();

        // Sustained contention: strict alternation starting with the LSU
        served_who.delete();
        served_cyc.delete();
        fork
            begin
                int wa;
                for (int i = 0; i < 4; i++) drive_req(1'b0, 32'(32'h40 + i * 8), wa);
            end
            begin
                int wb;
                for (int i = 0; i < 4; i++) drive_req(1'b1, 32'(32'h80 + i * 4), wb);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        alt_ok = (served_who.size() == 8);
        for (int i = 0; i < served_who.size(); i++) begin
            if (served_who[i] != ((i % 2) == 0)) alt_ok = 1'b0;
        end
        chk(alt_ok, "round_robin_alternation", 64'(served_who.size()), 8);

        // Faulting LSU accesses
        drive_req(1'b1, 32'h6, w1);
        @(negedge clk);
        chk(lsu_rsp_valid && lsu_rsp_err && lsu_rdata == 0, "lsu_misaligned",
            {lsu_rsp_valid, lsu_rsp_err, lsu_rdata}, {2'b11, 32'h0});
        @(posedge clk);
        #1 drive_req(1'b1, 32'h400, w1);
        @(negedge clk);
        chk(lsu_rsp_valid && lsu_rsp_err && lsu_rdata == 0, "lsu_out_of_range",
            {lsu_rsp_valid, lsu_rsp_err, lsu_rdata}, {2'b11, 32'h0});
        @(posedge clk);
        #1;

        // IFU back-pressure for 5 cycles with an LSU request waiting
        served_who.delete();
        served_cyc.delete();
        ifu_rsp_ready = 1'b0;
        e = model(32'h10);
        fork
            drive_req(1'b0, 32'h10, w0);
            begin
                @(posedge clk);
                #1 drive_req(1'b1, 32'h14, w1);
            end
            begin
                repeat (6) @(posedge clk);
                #1 ifu_rsp_ready = 1'b1;
            end
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk(ifu_rsp_valid && !ifu_rsp_ready && ifu_rdata == e.data, "ifu_hold_stable",
                        {ifu_rsp_valid, ifu_rdata}, {1'b1, e.data});
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk(served_who.size() == 2 && served_who[1] == 1'b1 && served_cyc[1] == last_ifu_hs + 1,
            "lsu_after_ifu_handshake", 64'(served_cyc.size() == 2 ? served_cyc[1] : -1),
            64'(last_ifu_hs + 1));

        // Reset while a response is outstanding
        ifu_rsp_ready = 1'b0;
        drive_req(1'b0, 32'h20, w0);
        #2 rst_n = 1'b0;
        ifu_q.delete();
        lsu_q.delete();
        #1;
        chk(!ifu_rsp_valid && ifu_rdata == 0, "rsp_drop_on_reset", {ifu_rsp_valid, ifu_rdata}, 0);
        ifu_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        served_who.delete();
        served_cyc.delete();
        fork
            drive_req(1'b0, 32'h30, w0);
            drive_req(1'b1, 32'h34, w1);
        join
        repeat (3) @(posedge clk);
        #1;
        chk(served_who.size() == 2 && served_who[0] == 1'b1, "prio_after_reset",
            64'(served_who.size() > 0 ? served_who[0] : 1'b0), 1);

        // Randomized traffic with random response back-pressure
        rdy_mode = 0;
        fork
            begin
                int wa;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 drive_req(1'b0, rand_addr(), wa);
                end
            end
            begin
                int wb;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1 drive_req(1'b1, rand_addr(), wb);
                end
            end
        join
        rdy_mode      = 1;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk(ifu_q.size() == 0 && lsu_q.size() == 0, "scoreboard_drained",
            {32'(ifu_q.size()), 32'(lsu_q.size())}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
